// File: rtl/i2s_pkg.sv
// Shared I2S definitions: slot-state enum and default frame/clock constants.
package i2s_pkg;

    localparam int unsigned WIDTH_DEF     = 24;
    localparam int unsigned SLOT_BITS_DEF = 32;
    localparam int unsigned BCLK_DIV_DEF  = 4;
    localparam int unsigned UCNT_W        = 16;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

endpackage

// File: rtl/i2s_if.sv
// Sample-pair handshake between the audio source and the I2S transmitter.
interface i2s_if #(
    parameter int unsigned WIDTH = 24
);
    logic [WIDTH-1:0] sample_left;
    logic [WIDTH-1:0] sample_right;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_clk_div.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk cycles; fall_c marks the clk where bclk goes 1->0.
module i2s_clk_div
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rstn,
    output logic bclk,
    output logic fall_c
);
    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             tick_c;

    assign tick_c = (div_q == DIV_LAST);
    assign fall_c = tick_c & bclk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            bclk  <= 1'b0;
        end else if (tick_c) begin
            div_q <= '0;
            bclk  <= ~bclk;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: one-entry holding register feeding per-channel shift registers.
// Optional feature macro: I2S_UNDERRUN_COUNT_EN enables the saturating underrun_count.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned SLOT_BITS = SLOT_BITS_DEF,
    parameter int unsigned BCLK_DIV  = BCLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    i2s_if.slave              sample,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_count
);
    localparam int unsigned CNT_W = $clog2(2 * SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);

    logic             fall_c;
    logic [CNT_W-1:0] bit_q, bit_d;
    slot_e            slot_q, slot_d;
    logic             frame_start_c;
    logic [CNT_W-1:0] pos_c;
    logic             shift_c;
    logic             accept_c;

    logic [WIDTH-1:0] hold_l, hold_r;
    logic [WIDTH-1:0] left_sh, right_sh;
    logic             ready_q;
    logic             sdata_q;
    logic             underrun_q;

    i2s_clk_div #(.BCLK_DIV(BCLK_DIV)) u_clk_div (
        .clk    (clk),
        .rstn   (rstn),
        .bclk   (bclk),
        .fall_c (fall_c)
    );

    assign accept_c            = sample.sample_valid & ready_q;
    assign sample.sample_ready = ready_q;
    assign lrclk               = (slot_q == SLOT_RIGHT);
    assign sdata               = sdata_q;
    assign underrun            = underrun_q;

    // Slot state and bit position; the counter starts at its last value so the first fall is a frame start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_q  <= CNT_LAST;
            slot_q <= SLOT_LEFT;
        end else begin
            bit_q  <= bit_d;
            slot_q <= slot_d;
        end
    end

    always_comb begin
        bit_d         = bit_q;
        slot_d        = slot_q;
        frame_start_c = 1'b0;
        pos_c         = '0;
        shift_c       = 1'b0;
        if (fall_c) begin
            frame_start_c = (bit_q == CNT_LAST);
            bit_d         = frame_start_c ? '0 : bit_q + CNT_W'(1);
            slot_d        = (bit_d >= CNT_W'(SLOT_BITS)) ? SLOT_RIGHT : SLOT_LEFT;
            pos_c         = (slot_d == SLOT_RIGHT) ? bit_d - CNT_W'(SLOT_BITS) : bit_d;
            shift_c       = (pos_c != '0) && (pos_c <= CNT_W'(WIDTH));
        end
    end

    // Holding register and serializer; an empty holding at frame start sends silence
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_l     <= '0;
            hold_r     <= '0;
            left_sh    <= '0;
            right_sh   <= '0;
            ready_q    <= 1'b1;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= frame_start_c & ready_q;

            if (fall_c) begin
                if (frame_start_c) begin
                    left_sh  <= ready_q ? '0 : hold_l;
                    right_sh <= ready_q ? '0 : hold_r;
                    sdata_q  <= 1'b0;
                end else if (shift_c) begin
                    if (slot_d == SLOT_LEFT) begin
                        sdata_q <= left_sh[WIDTH-1];
                        left_sh <= left_sh << 1;
                    end else begin
                        sdata_q  <= right_sh[WIDTH-1];
                        right_sh <= right_sh << 1;
                    end
                end else begin
                    sdata_q <= 1'b0;
                end
            end

            // A pair arriving on an underrun frame start is kept for the following frame
            if (frame_start_c && !ready_q) begin
                ready_q <= 1'b1;
            end else if (accept_c) begin
                hold_l  <= sample.sample_left;
                hold_r  <= sample.sample_right;
                ready_q <= 1'b0;
            end
        end
    end

`ifdef I2S_UNDERRUN_COUNT_EN
    logic [UCNT_W-1:0] ucnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ucnt_q <= '0;
        end else if (frame_start_c && ready_q && (ucnt_q != {UCNT_W{1'b1}})) begin
            ucnt_q <= ucnt_q + UCNT_W'(1);
        end
    end

    assign underrun_count = ucnt_q;
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// Randomized bench for i2s_transmitter with a frame-level reference model and per-cycle compare.
module tb_i2s_transmitter;

    localparam int W     = 24;
    localparam int SB    = 32;
    localparam int D     = 4;
    localparam int FIRST = 2 * D;
    localparam int FRAME = 2 * SB * 2 * D;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        bclk, lrclk, sdata, underrun;
    logic [15:0] ucnt;

    always #5 clk = ~clk;

    i2s_if #(.WIDTH(W)) sif ();

    i2s_transmitter #(.WIDTH(W), .SLOT_BITS(SB), .BCLK_DIV(D)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .sample         (sif),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .sdata          (sdata),
        .underrun       (underrun),
        .underrun_count (ucnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset release, one-deep holding, pair of the current frame
    int          m_n;
    bit          m_full;
    logic [W-1:0] m_hl, m_hr, m_cl, m_cr;
    bit          m_und;
    int          m_cnt;
    bit          m_fs, m_hs;

    initial begin
        m_n = 0; m_full = 0; m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0; m_und = 0; m_cnt = 0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_n = 0; m_full = 0; m_cl = '0; m_cr = '0; m_und = 0; m_cnt = 0;
            end else begin
                m_n++;
                m_fs  = (m_n >= FIRST) && ((m_n - FIRST) % FRAME == 0);
                m_hs  = sif.sample_valid && !m_full;
                m_und = m_fs && !m_full;
                if (m_fs && m_full) begin
                    m_cl = m_hl; m_cr = m_hr; m_full = 0;
                end else begin
                    if (m_fs) begin
                        m_cl = '0; m_cr = '0;
                        if (m_cnt < 65535) m_cnt++;
                    end
                    if (m_hs) begin
                        m_hl = sif.sample_left; m_hr = sif.sample_right; m_full = 1;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus capture of each completed frame's serial bits
    logic [2*SB-1:0] cap;
    logic [W-1:0]    last_l, last_r;
    bit              pad_ok;
    int              frames_done;

    initial begin
        int m, pos, p;
        logic [W-1:0] w;
        logic e_lr, e_sd;
        cap = '0; last_l = '0; last_r = '0; pad_ok = 1; frames_done = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_bclk", 32'(bclk), 32'd0);
                check("rst_lrclk", 32'(lrclk), 32'd0);
                check("rst_sdata", 32'(sdata), 32'd0);
                check("rst_ready", 32'(sif.sample_ready), 32'd1);
                check("rst_underrun", 32'(underrun), 32'd0);
                check("rst_ucnt", 32'(ucnt), 32'd0);
                frames_done = 0;
            end else begin
                m = m_n / (2 * D);
                e_lr = 1'b0; e_sd = 1'b0; pos = 0;
                if (m > 0) begin
                    pos  = (m - 1) % (2 * SB);
                    e_lr = (pos >= SB);
                    p    = pos % SB;
                    w    = (pos < SB) ? m_cl : m_cr;
                    if (p >= 1 && p <= W) e_sd = w[W-p];
                end
                check("bclk", 32'(bclk), 32'((m_n / D) % 2));
                check("lrclk", 32'(lrclk), 32'(e_lr));
                check("sdata", 32'(sdata), 32'(e_sd));
                check("ready", 32'(sif.sample_ready), 32'(!m_full));
                check("underrun", 32'(underrun), 32'(m_und));
`ifdef I2S_UNDERRUN_COUNT_EN
                check("ucnt", 32'(ucnt), 32'(m_cnt));
`else
                check("ucnt", 32'(ucnt), 32'd0);
`endif
                if (m > 0 && (m_n % (2 * D) == 0)) begin
                    cap[pos] = sdata;
                    if (pos == 2 * SB - 1) begin
                        pad_ok = 1;
                        for (int i = 1; i <= W; i++) begin
                            last_l[W-i] = cap[i];
                            last_r[W-i] = cap[SB+i];
                        end
                        for (int q = 0; q < SB; q++)
                            if ((q == 0 || q > W) && (cap[q] !== 1'b0 || cap[SB+q] !== 1'b0)) pad_ok = 0;
                        frames_done++;
                    end
                end
            end
        end
    end

    function automatic int next_fs(input int n);
        if (n < FIRST) return FIRST;
        return FIRST + ((n - FIRST) / FRAME + 1) * FRAME;
    endfunction

    task automatic wait_n(input int target);
        int budget = 20000;
        while (m_n < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("wait_timeout", 32'(m_n), 32'(target));
    endtask

    initial begin
        int hs_edge, target, und_seen, first_und, budget;
        sif.sample_valid = 1'b0;
        sif.sample_left  = '0;
        sif.sample_right = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("lit_rst_ready", 32'(sif.sample_ready), 32'd1);
        check("lit_rst_bclk", 32'(bclk), 32'd0);
        @(posedge clk); #2 rstn = 1'b1;

        // No valid: first frame start at edge 8 is an underrun
        wait_n(7);
        check("lit_bclk_hi_n7", 32'(bclk), 32'd1);
        check("lit_no_und_n7", 32'(underrun), 32'd0);
        wait_n(8);
        check("lit_first_underrun", 32'(underrun), 32'd1);

        // Offer the reference pair during frame 0
        sif.sample_left  = 24'hA50F3C;
        sif.sample_right = 24'h800001;
        sif.sample_valid = 1'b1;
        @(negedge clk);
        sif.sample_valid = 1'b0;
        check("lit_ready_dropped", 32'(sif.sample_ready), 32'd0);
        wait_n(FIRST + FRAME);
        check("lit_frame0_left", 32'(last_l), 32'd0);
        check("lit_frame0_right", 32'(last_r), 32'd0);
        check("lit_frame0_pad", 32'(pad_ok), 32'd1);
        check("lit_frame1_no_und", 32'(underrun), 32'd0);
        check("lit_ready_after_fs", 32'(sif.sample_ready), 32'd1);
        wait_n(FIRST + 2 * FRAME);
        check("lit_frame1_left", 32'(last_l), 32'hA50F3C);
        check("lit_frame1_right", 32'(last_r), 32'h800001);
        check("lit_frame1_pad", 32'(pad_ok), 32'd1);

        // Valid held high; data scrambled whenever the holding is full
        sif.sample_valid = 1'b1;
        und_seen = 0;
        target = m_n + 3 * FRAME;
        while (m_n < target) begin
            @(negedge clk);
            if (underrun) und_seen++;
            if (!sif.sample_ready) begin
                sif.sample_left  = W'($urandom);
                sif.sample_right = W'($urandom);
            end
        end
        sif.sample_valid = 1'b0;
        check("lit_stream_no_underrun", 32'(und_seen), 32'd0);

        // Handshake exactly on a frame start with empty holding
        hs_edge = next_fs(next_fs(m_n));
        wait_n(hs_edge - 1);
        sif.sample_left  = 24'h123456;
        sif.sample_right = 24'hFEDCBA;
        sif.sample_valid = 1'b1;
        @(negedge clk);
        sif.sample_valid = 1'b0;
        check("lit_coincide_underrun", 32'(underrun), 32'd1);
        check("lit_coincide_held", 32'(sif.sample_ready), 32'd0);
        wait_n(hs_edge + 2 * FRAME);
        check("lit_coincide_left", 32'(last_l), 32'h123456);
        check("lit_coincide_right", 32'(last_r), 32'hFEDCBA);

        // Random offers
        target = m_n + 2 * FRAME;
        while (m_n < target) begin
            @(negedge clk);
            sif.sample_valid = ($urandom_range(0, 15) == 0);
            if (sif.sample_valid) begin
                sif.sample_left  = W'($urandom);
                sif.sample_right = W'($urandom);
            end
        end
        sif.sample_valid = 1'b0;

        // Reset in the middle of the right slot
        target = next_fs(m_n) + 300;
        wait_n(target);
        check("lit_in_right_slot", 32'(lrclk), 32'd1);
        @(posedge clk); #2 rstn = 1'b0;
        #1;
        check("lit_mid_rst_bclk", 32'(bclk), 32'd0);
        check("lit_mid_rst_lrclk", 32'(lrclk), 32'd0);
        check("lit_mid_rst_sdata", 32'(sdata), 32'd0);
        check("lit_mid_rst_ready", 32'(sif.sample_ready), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rstn = 1'b1;
        first_und = -1;
        budget = 40;
        while (first_und < 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (underrun) first_und = m_n;
        end
        check("lit_restart_edge", 32'(first_und), 32'd8);

        // Three starved frames since reset
        wait_n(FIRST + 2 * FRAME + 1);
`ifdef I2S_UNDERRUN_COUNT_EN
        check("lit_ucnt_three", 32'(ucnt), 32'd3);
`else
        check("lit_ucnt_tied", 32'(ucnt), 32'd0);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample width in bits (two's complement).
REQ-002 SHALL have parameter SLOT_BITS, default 32, bclk periods per channel slot; WIDTH <= SLOT_BITS-1.
REQ-003 SHALL have parameter BCLK_DIV, default 4, clk cycles per bclk half-period; BCLK_DIV >= 2.
REQ-004 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port sample_left  in  WIDTH  left-channel sample.
REQ-007 SHALL have port sample_right  in  WIDTH  right-channel sample.
REQ-008 SHALL have port sample_valid  in  1  sample pair offered.
REQ-009 SHALL have port sample_ready  out  1  holding register empty.
REQ-010 SHALL have port bclk  out  1  I2S bit clock.
REQ-011 SHALL have port lrclk  out  1  word select; 0 = left, 1 = right.
REQ-012 SHALL have port sdata  out  1  serial data, MSB first.
REQ-013 SHALL have port underrun  out  1  one-clk pulse when a frame starts with no sample.
REQ-014 SHALL have port underrun_count  out  16  saturating underrun count (see Configuration).

Function
REQ-015 SHALL accept a sample pair into the holding register on any clk where sample_valid && sample_ready; sample_ready then drops next cycle.
REQ-016 SHALL toggle bclk on the clk where divider counter (0..BCLK_DIV-1) equals BCLK_DIV-1; the counter wraps to 0.
REQ-017 SHALL treat the clk where bclk goes 1->0 as a falling-edge event; bit counter (0..2*SLOT_BITS-1) advances on each event and wraps.
REQ-018 SHALL drive lrclk = 0 for bit counter < SLOT_BITS, else 1, updated on the falling-edge event.
REQ-019 SHALL drive sdata at slot position p: sample bit (WIDTH-p) for 1 <= p <= WIDTH; 0 for p = 0 and p > WIDTH (Philips one-bit delay, zero pad).
REQ-020 SHALL treat the falling-edge event where the bit counter wraps to 0 as frame start: load both shift registers from holding if full, clear holding, raise sample_ready next clk.
REQ-021 SHALL, at frame start with holding empty, load zeros into both shift registers and pulse underrun for that one clk.
REQ-022 SHALL, when a handshake and a frame start with empty holding coincide, treat the frame as underrun; the new pair is held for the next frame.
REQ-023 SHALL keep the held pair unchanged while sample_ready is low, regardless of sample_valid and data inputs.
REQ-024 SHALL output sdata, lrclk, bclk changes only on clk edges; no combinational path from inputs to serial outputs.

Reset
REQ-025 SHALL, on rstn low, asynchronously force bclk=0, lrclk=0, sdata=0, sample_ready=1, underrun=0, underrun_count=0, holding empty, divider=0.
REQ-026 SHALL reset the bit counter to 2*SLOT_BITS-1 so the first falling edge after reset (clk 2*BCLK_DIV) is a frame start.
REQ-027 SHALL abandon any in-progress frame on reset mid-operation; no partial bits resume.

Configuration
REQ-028 SHALL implement underrun_count only when I2S_UNDERRUN_COUNT_EN is defined: increments per underrun pulse, saturates at 16'hFFFF.
REQ-029 SHALL, without I2S_UNDERRUN_COUNT_EN, tie underrun_count to 0; underrun pulse unaffected.

Structure
REQ-030 SHALL place slot-state enum (SLOT_LEFT, SLOT_RIGHT) and default SLOT_BITS/BCLK_DIV constants in shared package i2s_pkg.
REQ-031 SHALL use one sub-module i2s_clk_div producing bclk and falling-edge strobe.

Verification (WIDTH=24, SLOT_BITS=32, BCLK_DIV=4; frame = 512 clk)
REQ-032 SHALL cover: reset release, no valid -> first frame start at clk 8, underrun pulse, sdata 0 for all 64 bits.
REQ-033 SHALL cover: pair L=24'hA5_0F3C, R=24'h80_0001 before frame 1 -> left slot bits 1..24 = A50F3C MSB first, bit 0 and 25..31 zero; right = 800001.
REQ-034 SHALL cover: valid held high continuously -> one pair accepted per frame, sample_ready high one clk after each frame start, no underrun.
REQ-035 SHALL cover: handshake on exact frame-start clk with empty holding -> underrun that frame, pair transmitted next frame.
REQ-036 SHALL cover: rstn low mid-right-slot -> all outputs zero same cycle, sample_ready=1, restart at clk 8 after release.
REQ-037 SHALL cover: with I2S_UNDERRUN_COUNT_EN, 3 starved frames -> underrun_count=3; without macro -> 0.
